// File: rtl/cma_host_pkg.sv
// Shared encodings and bus widths for the CMA host-side bus master.
package cma_host_pkg;

  localparam int A_W     = 12;
  localparam int D_W     = 25;
  localparam int ROMUL_W = 20;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_RUN   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    IDLE,
    WR_SETUP,
    WR_STB,
    WR_HOLD,
    RD_STB,
    RD_WAIT,
    RUN_HI,
    RUN_WAIT,
    RSP
  } state_e;

endpackage

// File: rtl/cma_done_sync.sv
// Two-flop synchronizer bringing the chip DONE flag into the host clock domain.
module cma_done_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/cma_host_ctrl.sv
// Host-side master for the CMA external bus: sequences WRITE/READ/RUN commands
// into registered pad strobes and returns READ data / RUN status on a response channel.
module cma_host_ctrl
  import cma_host_pkg::*;
#(
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned RUN_PULSE = 2,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [A_W-1:0]     cmd_addr_i,
  input  logic [D_W-1:0]     cmd_wdata_i,
  input  logic [ROMUL_W-1:0] cmd_romul_i,
  input  logic               cmd_bank_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [D_W-1:0]     rsp_data_o,
  output logic               rsp_err_o,
  output logic               exwe_o,
  output logic               exre_o,
  output logic [A_W-1:0]     exa_o,
  output logic [D_W-1:0]     exwd_o,
  output logic [ROMUL_W-1:0] exromul_o,
  output logic               cbank_o,
  output logic               run_o,
  input  logic [D_W-1:0]     exrd_i,
  input  logic               done_i
);

  localparam logic [3:0]  RD_LAST   = 4'(RD_LAT - 1);
  localparam logic [3:0]  RUN_LAST  = 4'(RUN_PULSE - 1);
  localparam logic [12:0] WAIT_LAST = 13'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic                 exwe_q, exwe_d;
  logic                 exre_q, exre_d;
  logic                 run_q, run_d;
  logic [A_W-1:0]       exa_q, exa_d;
  logic [D_W-1:0]       exwd_q, exwd_d;
  logic [ROMUL_W-1:0]   exromul_q, exromul_d;
  logic                 cbank_q, cbank_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [D_W-1:0]       rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [12:0]          wait_q, wait_d;
  logic                 done_sync;
  logic                 accept;

  cma_done_sync u_done_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (done_i),
    .sync_o  (done_sync)
  );

  assign cmd_ready_o = (state_q == IDLE) && !rsp_valid_q && !rst_i;
  assign accept      = cmd_valid_i && cmd_ready_o;

  always_comb begin
    state_d     = state_q;
    exa_d       = exa_q;
    exwd_d      = exwd_q;
    exromul_d   = exromul_q;
    cbank_d     = cbank_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          exromul_d = cmd_romul_i;
          case (op_e'(cmd_op_i))
            OP_WRITE: begin
              exa_d   = cmd_addr_i;
              exwd_d  = cmd_wdata_i;
              state_d = WR_SETUP;
            end
            OP_READ: begin
              exa_d   = cmd_addr_i;
              cnt_d   = 4'd0;
              state_d = RD_STB;
            end
            OP_RUN: begin
              cbank_d = cmd_bank_i;
              cnt_d   = 4'd0;
              state_d = RUN_HI;
            end
            default: ;
          endcase
        end
      end
      WR_SETUP: state_d = WR_STB;
      WR_STB:   state_d = WR_HOLD;
      WR_HOLD:  state_d = IDLE;
      // cnt_q counts edges since EXRE rose; the strobe cycle itself is count 0
      RD_STB, RD_WAIT: begin
        if (cnt_q == RD_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = exrd_i;
          rsp_err_d   = 1'b0;
          state_d     = RSP;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = RD_WAIT;
        end
      end
      RUN_HI: begin
        if (cnt_q == RUN_LAST) begin
          wait_d  = 13'd0;
          state_d = RUN_WAIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RUN_WAIT: begin
        if (done_sync) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
          state_d     = RSP;
        end else if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = RSP;
        end else if (wait_q != '1) begin
          wait_d = wait_q + 13'd1;
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they leave the chip as clean flop outputs
  assign exwe_d = (state_d == WR_STB);
  assign exre_d = (state_d == RD_STB);
  assign run_d  = (state_d == RUN_HI);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      exwe_q      <= 1'b0;
      exre_q      <= 1'b0;
      run_q       <= 1'b0;
      exa_q       <= '0;
      exwd_q      <= '0;
      exromul_q   <= '0;
      cbank_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= 4'd0;
      wait_q      <= 13'd0;
    end else begin
      state_q     <= state_d;
      exwe_q      <= exwe_d;
      exre_q      <= exre_d;
      run_q       <= run_d;
      exa_q       <= exa_d;
      exwd_q      <= exwd_d;
      exromul_q   <= exromul_d;
      cbank_q     <= cbank_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
    end
  end

  assign exwe_o      = exwe_q;
  assign exre_o      = exre_q;
  assign run_o       = run_q;
  assign exa_o       = exa_q;
  assign exwd_o      = exwd_q;
  assign exromul_o   = exromul_q;
  assign cbank_o     = cbank_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_cma_host_ctrl.sv
// Bench for cma_host_ctrl: chip memory/DONE model, response scoreboard, vector table
// and hand-written sequences for strobe timing, back-pressure and mid-operation reset.
module tb_cma_host_ctrl;
  import cma_host_pkg::*;

  localparam int RD_LAT    = 2;
  localparam int RUN_PULSE = 2;
  localparam int TIMEOUT   = 16;
  localparam int NVEC      = 12;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [24:0] wdata;
    logic [19:0] romul;
    logic        bank;
    int          doneDelay;
    bit          expRsp;
    logic [24:0] expData;
    logic        expErr;
  } vec_t;

  typedef struct {
    logic [24:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i = 2'd0;
  logic [11:0] cmd_addr_i = '0;
  logic [24:0] cmd_wdata_i = '0;
  logic [19:0] cmd_romul_i = '0;
  logic        cmd_bank_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [24:0] rsp_data_o;
  logic        rsp_err_o;
  logic        exwe_o, exre_o, cbank_o, run_o;
  logic [11:0] exa_o;
  logic [24:0] exwd_o;
  logic [19:0] exromul_o;
  logic [24:0] exrd_i = '0;
  logic        done_i = 1'b0;

  int   checks = 0;
  int   errors = 0;
  rsp_t sb[$];
  rsp_t monExp;
  int   expRsp = 0;
  int   gotRsp = 0;

  logic [24:0] mem [0:4095];
  logic [11:0] rdAddr = '0;
  int          rdAge = 0;
  int          doneDelay = 0;
  logic        runPrev = 1'b0;
  bit          armed = 1'b0;
  int          doneAge = 0;
  logic        bankExp = 1'b0;
  vec_t        vecs [NVEC];

  always #5 clk = ~clk;

  cma_host_ctrl #(.RD_LAT(RD_LAT), .RUN_PULSE(RUN_PULSE), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_romul_i(cmd_romul_i),
    .cmd_bank_i(cmd_bank_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o),
    .exwe_o(exwe_o), .exre_o(exre_o), .exa_o(exa_o), .exwd_o(exwd_o),
    .exromul_o(exromul_o), .cbank_o(cbank_o), .run_o(run_o),
    .exrd_i(exrd_i), .done_i(done_i)
  );

  // Chip memory: EXRD carries valid data only on the cycle whose closing edge is RD_LAT edges after EXRE rose
  always @(negedge clk) begin
    if (exwe_o) mem[exa_o] = exwd_o;
    if (exre_o) begin
      rdAddr = exa_o;
      rdAge  = 1;
    end else if (rdAge != 0 && rdAge < 100) begin
      rdAge++;
    end
    exrd_i = (rdAge == RD_LAT) ? mem[rdAddr] : 25'h1555555;
  end

  // Chip DONE: raised doneDelay cycles after RUN falls (0 = never), cleared by the next RUN
  always @(posedge clk) begin
    #1;
    if (run_o) begin
      done_i = 1'b0;
      armed  = 1'b0;
    end else if (runPrev) begin
      armed   = (doneDelay > 0);
      doneAge = 0;
    end else if (armed) begin
      doneAge++;
      if (doneAge == doneDelay) begin
        done_i = 1'b1;
        armed  = 1'b0;
      end
    end
    runPrev = run_o;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_i && rsp_valid_o && rsp_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got data=%h err=%b, required no response", rsp_data_o, rsp_err_o);
      end else begin
        monExp = sb.pop_front();
        checkOutput("rsp_data", 32'(rsp_data_o), 32'(monExp.data));
        checkOutput("rsp_err", 32'(rsp_err_o), 32'(monExp.err));
        gotRsp++;
      end
    end
  end

  function automatic vec_t mkVec(input logic [1:0] op, input logic [11:0] addr,
                                 input logic [24:0] wdata, input logic [19:0] romul,
                                 input logic bank, input int dly, input bit er,
                                 input logic [24:0] ed, input logic ee);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.romul = romul; v.bank = bank;
    v.doneDelay = dly; v.expRsp = er; v.expData = ed; v.expErr = ee;
    return v;
  endfunction

  // Called just after a rising edge; returns 1 ns after the edge that accepted the command
  task automatic applyStimulus(input vec_t v);
    int n;
    rsp_t e;
    n = 0;
    cmd_op_i = v.op; cmd_addr_i = v.addr; cmd_wdata_i = v.wdata;
    cmd_romul_i = v.romul; cmd_bank_i = v.bank; cmd_valid_i = 1'b1;
    @(negedge clk);
    while (!cmd_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got cmd_ready=0 for 200 cycles, required 1");
    end else if (v.expRsp) begin
      e.data = v.expData;
      e.err  = v.expErr;
      sb.push_back(e);
      expRsp++;
    end
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: got cmd_ready=0 for 200 cycles, required 1");
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int runSeen;
    mem[12'h045] = 25'h0055AA5;

    vecs[0]  = mkVec(OP_WRITE, 12'h123, 25'h1ABCDEF, 20'h11111, 1'b0, 0, 1'b0, 25'h0, 1'b0);
    vecs[1]  = mkVec(OP_READ,  12'h123, 25'h0,       20'h22222, 1'b1, 0, 1'b1, 25'h1ABCDEF, 1'b0);
    vecs[2]  = mkVec(OP_WRITE, 12'h000, 25'h0000001, 20'h33333, 1'b0, 0, 1'b0, 25'h0, 1'b0);
    vecs[3]  = mkVec(OP_WRITE, 12'hFFF, 25'h1FFFFFF, 20'hFFFFF, 1'b1, 0, 1'b0, 25'h0, 1'b0);
    vecs[4]  = mkVec(OP_READ,  12'hFFF, 25'h0,       20'h00001, 1'b0, 0, 1'b1, 25'h1FFFFFF, 1'b0);
    vecs[5]  = mkVec(OP_READ,  12'h000, 25'h0,       20'h44444, 1'b0, 0, 1'b1, 25'h0000001, 1'b0);
    vecs[6]  = mkVec(OP_RUN,   12'h000, 25'h0,       20'h55555, 1'b1, 5, 1'b1, 25'h0, 1'b0);
    vecs[7]  = mkVec(OP_RUN,   12'h000, 25'h0,       20'h66666, 1'b0, 0, 1'b1, 25'h0, 1'b1);
    vecs[8]  = mkVec(OP_RSVD,  12'h777, 25'h1234567, 20'h77777, 1'b1, 0, 1'b0, 25'h0, 1'b0);
    vecs[9]  = mkVec(OP_READ,  12'h045, 25'h0,       20'h88888, 1'b1, 0, 1'b1, 25'h0055AA5, 1'b0);
    vecs[10] = mkVec(OP_RUN,   12'h000, 25'h0,       20'h99999, 1'b1, 1, 1'b1, 25'h0, 1'b0);
    vecs[11] = mkVec(OP_READ,  12'h045, 25'h0,       20'hAAAAA, 1'b0, 0, 1'b1, 25'h0055AA5, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
    checkOutput("rst_exwe", 32'(exwe_o), 32'd0);
    checkOutput("rst_exre", 32'(exre_o), 32'd0);
    checkOutput("rst_run", 32'(run_o), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("rst_exa", 32'(exa_o), 32'd0);
    checkOutput("rst_exwd", 32'(exwd_o), 32'd0);
    checkOutput("rst_exromul", 32'(exromul_o), 32'd0);
    checkOutput("rst_cbank", 32'(cbank_o), 32'd0);
    step();
    rst_i = 1'b0;
    step();

    $display("[TB] write strobe timing");
    applyStimulus(mkVec(OP_WRITE, 12'h123, 25'h1ABCDEF, 20'h0F0F0, 1'b0, 0, 1'b0, 25'h0, 1'b0));
    @(negedge clk);
    checkOutput("wr_setup_exwe", 32'(exwe_o), 32'd0);
    checkOutput("wr_setup_exa", 32'(exa_o), 32'h123);
    checkOutput("wr_setup_exwd", 32'(exwd_o), 32'h1ABCDEF);
    checkOutput("wr_setup_ready", 32'(cmd_ready_o), 32'd0);
    @(negedge clk);
    checkOutput("wr_stb_exwe", 32'(exwe_o), 32'd1);
    checkOutput("wr_stb_exa", 32'(exa_o), 32'h123);
    checkOutput("wr_stb_exwd", 32'(exwd_o), 32'h1ABCDEF);
    @(negedge clk);
    checkOutput("wr_hold_exwe", 32'(exwe_o), 32'd0);
    checkOutput("wr_hold_exa", 32'(exa_o), 32'h123);
    checkOutput("wr_hold_exwd", 32'(exwd_o), 32'h1ABCDEF);
    checkOutput("wr_hold_ready", 32'(cmd_ready_o), 32'd0);
    @(negedge clk);
    checkOutput("wr_done_ready", 32'(cmd_ready_o), 32'd1);
    checkOutput("wr_idle_exa", 32'(exa_o), 32'h123);
    checkOutput("wr_idle_exwe", 32'(exwe_o), 32'd0);
    step();

    $display("[TB] read pulse and latency");
    applyStimulus(mkVec(OP_READ, 12'h045, 25'h0, 20'h0, 1'b0, 0, 1'b1, 25'h0055AA5, 1'b0));
    @(negedge clk);
    checkOutput("rd_stb_exre", 32'(exre_o), 32'd1);
    checkOutput("rd_stb_exa", 32'(exa_o), 32'h045);
    @(negedge clk);
    checkOutput("rd_wait_exre", 32'(exre_o), 32'd0);
    checkOutput("rd_wait_rsp_valid", 32'(rsp_valid_o), 32'd0);
    @(negedge clk);
    checkOutput("rd_rsp_valid", 32'(rsp_valid_o), 32'd1);
    step();

    $display("[TB] run with DONE");
    doneDelay = 10;
    applyStimulus(mkVec(OP_RUN, 12'h0, 25'h0, 20'h0, 1'b1, 10, 1'b1, 25'h0, 1'b0));
    bankExp = 1'b1;
    @(negedge clk);
    checkOutput("run_hi1", 32'(run_o), 32'd1);
    checkOutput("run_cbank", 32'(cbank_o), 32'd1);
    @(negedge clk);
    checkOutput("run_hi2", 32'(run_o), 32'd1);
    @(negedge clk);
    checkOutput("run_fall", 32'(run_o), 32'd0);
    n = 0;
    while (!done_i && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", 32'(done_i), 32'd1);
    n = 0;
    while (!rsp_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    // Two synchronizer flops, then the response register
    checkOutput("done_to_rsp_edges", 32'(n), 32'd3);
    step();

    $display("[TB] run timeout");
    doneDelay = 0;
    applyStimulus(mkVec(OP_RUN, 12'h0, 25'h0, 20'h0, 1'b0, 0, 1'b1, 25'h0, 1'b1));
    bankExp = 1'b0;
    n = 0;
    @(negedge clk);
    while (run_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    runSeen = 0;
    while (!rsp_valid_o && n < 100) begin
      if (run_o) runSeen++;
      n++;
      @(negedge clk);
    end
    checkOutput("timeout_wait_cycles", 32'(n), 32'(TIMEOUT));
    checkOutput("timeout_run_low", 32'(runSeen), 32'd0);
    step();

    $display("[TB] response back-pressure");
    rsp_ready_i = 1'b0;
    applyStimulus(mkVec(OP_READ, 12'h045, 25'h0, 20'h0, 1'b0, 0, 1'b1, 25'h0055AA5, 1'b0));
    cmd_op_i = OP_WRITE; cmd_addr_i = 12'h200; cmd_wdata_i = 25'h0AAAAAA;
    cmd_romul_i = 20'h12345; cmd_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rsp_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("bp_rsp_data", 32'(rsp_data_o), 32'h0055AA5);
      checkOutput("bp_rsp_err", 32'(rsp_err_o), 32'd0);
      checkOutput("bp_cmd_ready", 32'(cmd_ready_o), 32'd0);
      @(negedge clk);
    end
    step();
    rsp_ready_i = 1'b1;
    @(negedge clk);
    checkOutput("bp_handshake_ready", 32'(cmd_ready_o), 32'd0);
    step();
    @(negedge clk);
    checkOutput("bp_after_ready", 32'(cmd_ready_o), 32'd1);
    checkOutput("bp_after_valid", 32'(rsp_valid_o), 32'd0);
    step();
    cmd_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("bp_wr_setup_exwe", 32'(exwe_o), 32'd0);
    checkOutput("bp_wr_exa", 32'(exa_o), 32'h200);
    @(negedge clk);
    checkOutput("bp_wr_stb_exwe", 32'(exwe_o), 32'd1);
    checkOutput("bp_wr_exwd", 32'(exwd_o), 32'h0AAAAAA);
    waitIdle();
    step();

    $display("[TB] reset during read wait");
    applyStimulus(mkVec(OP_READ, 12'h045, 25'h0, 20'h0, 1'b0, 0, 1'b1, 25'h0055AA5, 1'b0));
    step();
    rst_i = 1'b1;
    @(negedge clk);
    checkOutput("rst_rd_cmd_ready", 32'(cmd_ready_o), 32'd0);
    step();
    rst_i = 1'b0;
    sb.delete();
    expRsp--;
    bankExp = 1'b0;
    @(negedge clk);
    checkOutput("rst_rd_exre", 32'(exre_o), 32'd0);
    checkOutput("rst_rd_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("rst_rd_idle_ready", 32'(cmd_ready_o), 32'd1);
    step();

    $display("[TB] reset during write strobe");
    applyStimulus(mkVec(OP_WRITE, 12'h300, 25'h1234567, 20'h0, 1'b0, 0, 1'b0, 25'h0, 1'b0));
    step();
    rst_i = 1'b1;
    @(negedge clk);
    checkOutput("rst_wr_stb_exwe", 32'(exwe_o), 32'd1);
    step();
    rst_i = 1'b0;
    @(negedge clk);
    checkOutput("rst_wr_exwe", 32'(exwe_o), 32'd0);
    checkOutput("rst_wr_exre", 32'(exre_o), 32'd0);
    checkOutput("rst_wr_run", 32'(run_o), 32'd0);
    checkOutput("rst_wr_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("rst_wr_ready", 32'(cmd_ready_o), 32'd1);
    step();
    applyStimulus(mkVec(OP_READ, 12'h045, 25'h0, 20'h0, 1'b0, 0, 1'b1, 25'h0055AA5, 1'b0));
    waitIdle();
    step();

    $display("[TB] vector table");
    for (int i = 0; i < NVEC; i++) begin
      doneDelay = vecs[i].doneDelay;
      applyStimulus(vecs[i]);
      if (vecs[i].op == OP_RUN) bankExp = vecs[i].bank;
      waitIdle();
      checkOutput($sformatf("vec%0d_exromul", i), 32'(exromul_o), 32'(vecs[i].romul));
      checkOutput($sformatf("vec%0d_cbank", i), 32'(cbank_o), 32'(bankExp));
      step();
    end

    repeat (5) step();
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("rsp_count", 32'(gotRsp), 32'(expRsp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
